burst_array: RTL
================

Name: burst_array

Overview:
- Parametrised successor to the single-port word array used in the memory emulator.
- Adds DDR-style fixed-length bursts, per-byte write enables, a configurable read-latency pipeline, valid/ready command handshake and synchronous reset of all control state.
- Sits between the command/timing logic of an emulated bank and the on-chip BRAM that holds the bank contents.

Parameters:
- WIDTH, 8, data word width in bits; must be a multiple of 8.
- DEPTH, 2048, number of words; power of 2.
- BL, 8, burst length in beats; power of 2, 1 ≤ BL ≤ DEPTH.
- RD_LAT, 2, cycles from a read beat being issued to its rd_valid; must be ≥ 1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_wr  in  1  0 = read burst, 1 = write burst.
- cmd_addr  in  $clog2(DEPTH)  start word address.
- wr_data  in  WIDTH  write beat data.
- wr_be  in  WIDTH/8  byte enables for the write beat.
- rd_data  out  WIDTH  read beat data.
- rd_valid  out  1  rd_data holds a valid beat.
- busy  out  1  burst in progress or read pipeline not empty.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset state: IDLE; beat counter 0; cmd_ready=0 in any cycle where rst=1, then 1 from the first cycle after rst deasserts; rd_valid=0; rd_data=0; busy=0; read pipeline cleared.
- Memory contents are not reset. Simulation builds initialise every word to 0.
- A command is accepted in a cycle where cmd_valid && cmd_ready. cmd_ready is 1 only in IDLE.
- FSM:
  - IDLE → WRITE if an accepted command has cmd_wr=1.
  - IDLE → READ if an accepted command has cmd_wr=0.
  - WRITE/READ → IDLE after beat BL-1.
- Address of beat k: upper bits equal cmd_addr upper bits; low log2(BL) bits are (cmd_addr low bits + k) mod BL. This is a sequential wrap inside the BL-aligned block and never crosses into the next block.
- Timing: for a command accepted in cycle T, beat k occupies cycle T+1+k, for k = 0..BL-1.
- WRITE: in each beat cycle, wr_data and wr_be are sampled. Byte i of the addressed word is written iff wr_be[i]=1; other bytes keep their old value.
- READ: each beat cycle issues one read. The BRAM output register plus RD_LAT-1 further stages deliver that beat with rd_valid=1 in cycle T+1+k+RD_LAT.
- Ordering and rd_data:
  - Beats return in issue order.
  - rd_valid is never asserted for write beats.
  - rd_data holds its last value when rd_valid=0.
- Back-to-back commands: after the last beat the FSM is in IDLE, so cmd_ready=1 in cycle T+BL+1. The next command can be accepted then, which leaves exactly one idle cycle between bursts.
- A new command may be accepted while the read pipeline is still draining. Returned read data is unaffected.
- Read after write: a read beat addressing a word written by an earlier, completed write burst returns the new data.
- busy = (state ≠ IDLE) || (any read-pipeline valid bit set).
- Reset mid-burst: the burst is aborted immediately. Beats already written persist; the remaining beats are not written. Pending read beats are discarded and rd_valid=0 from the next cycle.
- cmd_valid=1 while rst=1 is ignored; no command is accepted.
- Out-of-state inputs: wr_data/wr_be outside WRITE beats, and cmd_* while cmd_ready=0, are don't-care and have no effect.

Decomposition:
- Package burst_array_pkg holds:
  - enum state_t {IDLE, WRITE, READ};
  - function wrap_addr(base, k) implementing the burst address rule.
- Sub-module be_ram (WIDTH, DEPTH): single-port BRAM with byte-enable write and a registered read. It carries the BRAM ramstyle attribute and is the only place the memory array is declared.
- burst_array holds the FSM, the beat counter and the RD_LAT-1 stage valid/data pipeline.

Test Plan:
- Reset then idle: rst=1 for 3 cycles with cmd_valid=1 → cmd_ready=0, rd_valid=0, busy=0 throughout reset; no write occurs; cmd_ready=1 in the first cycle after rst falls.
- Aligned burst (WIDTH=32, BL=8, RD_LAT=2):
  - write at addr 0x10, data 0xA0+k, wr_be=4'hF;
  - then read at 0x10 → rd_valid high for 8 consecutive cycles, first at acceptance+3;
  - rd_data = 0xA0..0xA7.
- Wrapped burst: write at 0x13 with data k → words 0x13..0x17 = 0..4 and 0x10..0x12 = 5..7; word 0x18 is unchanged.
- Byte enables: word 0x20 = 0x11223344; write one beat with 0xAABBCCDD and wr_be=4'b0101 → read back 0x11BB33DD.
- Back-to-back and drain:
  - read burst immediately followed by a write burst accepted at T+BL+1;
  - read beats still arrive in order with correct data;
  - busy stays high until the last rd_valid.
- Reset mid-read: assert rst during beat 3 of a read → rd_valid=0 the next cycle with no further beats; FSM in IDLE; memory contents unchanged.

Source files
------------

// File: rtl/burst_array_pkg.sv
// Shared types and the burst address rule for burst_array.
package burst_array_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  // Beat k address: keep the bits above the burst block, wrap the low bits inside it.
  function automatic logic [31:0] wrap_addr(input logic [31:0] base,
                                            input logic [31:0] k,
                                            input int unsigned bl);
    logic [31:0] mask;
    mask = 32'(bl) - 32'd1;
    return (base & ~mask) | ((base + k) & mask);
  endfunction

endpackage

// File: rtl/burst_array_be_ram.sv
// Single-port block RAM with per-byte write enables and a registered read port.
module be_ram #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2048
) (
  input  logic                     clk,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic                     we_i,
  input  logic [WIDTH/8-1:0]       be_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o
);

  localparam int unsigned NB = WIDTH / 8;

  (* ram_style = "block" *) logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Byte-masked write; array contents are never reset.
  always_ff @(posedge clk) begin
    if (en_i && we_i) begin
      for (int i = 0; i < NB; i++) begin
        if (be_i[i]) mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
      end
    end
  end

  // Output register only loads on a read so it holds between read beats.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (en_i && !we_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/burst_array.sv
// Burst-oriented word array: fixed-length wrapped bursts, byte-enable writes,
// configurable read latency and a valid/ready command port.
module burst_array
  import burst_array_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 2048,
  parameter int unsigned BL     = 8,
  parameter int unsigned RD_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_wr,
  input  logic [$clog2(DEPTH)-1:0] cmd_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [WIDTH/8-1:0]       wr_be,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (BL > 1) ? $clog2(BL) : 1;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [AW-1:0]     base_q;
  logic [AW-1:0]     beat_addr;
  logic              ram_en;
  logic              ram_we;
  logic              rd_issue;
  logic [WIDTH-1:0]  ram_rdata;
  logic [RD_LAT-1:0] vld_q;

  // Burst FSM with beat counter; a command is taken whenever IDLE and out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            base_q  <= cmd_addr;
            cnt_q   <= '0;
            state_q <= cmd_wr ? WRITE : READ;
          end
        end
        WRITE, READ: begin
          if (cnt_q == CW'(BL - 1)) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // cmd_ready must drop in the same cycle rst is raised, so it is decoded from rst directly.
  assign cmd_ready = (state_q == IDLE) && !rst;
  assign busy      = (state_q != IDLE) || (|vld_q);

  assign beat_addr = AW'(wrap_addr(32'(base_q), 32'(cnt_q), BL));
  assign ram_en    = !rst && (state_q != IDLE);
  assign ram_we    = (state_q == WRITE);
  assign rd_issue  = ram_en && (state_q == READ);

  be_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst_i   (rst),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .be_i    (wr_be),
    .addr_i  (beat_addr),
    .wdata_i (wr_data),
    .rdata_o (ram_rdata)
  );

  // Valid shift register; stage 0 lines up with the RAM output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= rd_issue;
      for (int i = 1; i < RD_LAT; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  assign rd_valid = vld_q[RD_LAT-1];

  if (RD_LAT == 1) begin : g_direct
    assign rd_data = ram_rdata;
  end else begin : g_pipe
    logic [WIDTH-1:0] dat_q [RD_LAT-1];

    // Data stages only advance with a valid beat so the last stage holds between beats.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < RD_LAT - 1; i++) dat_q[i] <= '0;
      end else begin
        if (vld_q[0]) dat_q[0] <= ram_rdata;
        for (int i = 1; i < RD_LAT - 1; i++) begin
          if (vld_q[i]) dat_q[i] <= dat_q[i-1];
        end
      end
    end

    assign rd_data = dat_q[RD_LAT-2];
  end

endmodule
